// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - parametrised VGA timing generator and framebuffer scanout engine
// Optional FB_PAGE_EN adds a display-page MSB to fb_addr, latched at the start of vertical blanking.
module vga_scanout #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 400,
  parameter int V_FRONT         = 11,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 32,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int SCALE_SHIFT     = 2,
  parameter int FB_COLS_LOG     = 8,
  parameter int FB_ROWS_LOG     = 7,
  parameter int PIXEL_W         = 8,
  parameter int RD_LATENCY      = 1,
`ifdef FB_PAGE_EN
  localparam int ADDR_W         = FB_ROWS_LOG + FB_COLS_LOG + 1
`else
  localparam int ADDR_W         = FB_ROWS_LOG + FB_COLS_LOG
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_en,
  input  logic               page_sel,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic               fb_rd_en,
  input  logic [PIXEL_W-1:0] fb_data,
  output logic [PIXEL_W-1:0] rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               frame_start,
  output logic [15:0]        hpos,
  output logic [15:0]        vpos
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS  = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS  = 16'(V_VISIBLE);
  localparam logic [15:0] HS_BEG = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END = 16'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        SYNC_INV = (SYNC_ACTIVE_LOW != 0);

  if (RD_LATENCY < 1 || RD_LATENCY > 4 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_param
    $error("vga_scanout: RD_LATENCY must be 1..4 and sync/porch widths nonzero");
  end

  logic [15:0]       r_hpos;
  logic [15:0]       r_vpos;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [3:0]        r_pipe [RD_LATENCY];
  logic              r_adv;
  logic              w_visible;
  logic              w_hpulse;
  logic              w_vpulse;
  logic              w_frame;
  logic [3:0]        w_in;
  logic [ADDR_W-1:0] w_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else if (pix_en) begin
      if (r_hpos == H_LAST) begin
        r_hpos <= '0;
        r_vpos <= (r_vpos == V_LAST) ? 16'd0 : r_vpos + 16'd1;
      end else begin
        r_hpos <= r_hpos + 16'd1;
      end
    end
  end

  assign w_visible = (r_hpos < H_VIS) && (r_vpos < V_VIS);
  assign w_hpulse  = (r_hpos >= HS_BEG) && (r_hpos < HS_END);
  assign w_vpulse  = (r_vpos >= VS_BEG) && (r_vpos < VS_END);
  assign w_frame   = (r_hpos == 16'd0) && (r_vpos == 16'd0);
  assign w_in      = {w_frame, w_vpulse, w_hpulse, w_visible};

`ifdef FB_PAGE_EN
  logic r_page;

  // Sampled at the first blank line so the whole next frame reads one page.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_page <= 1'b0;
    else if (pix_en && r_hpos == 16'd0 && r_vpos == V_VIS) r_page <= page_sel;
  end

  assign w_addr = {r_page, r_vpos[SCALE_SHIFT +: FB_ROWS_LOG], r_hpos[SCALE_SHIFT +: FB_COLS_LOG]};
`else
  logic w_unused_page;
  assign w_unused_page = page_sel;
  assign w_addr = {r_vpos[SCALE_SHIFT +: FB_ROWS_LOG], r_hpos[SCALE_SHIFT +: FB_COLS_LOG]};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_addr_hold <= '0;
    else if (pix_en && w_visible) r_addr_hold <= w_addr;
  end

  assign fb_addr  = w_visible ? w_addr : r_addr_hold;
  assign fb_rd_en = w_visible & pix_en;

  // Last stage is the output register, so pins trail the counters by exactly RD_LATENCY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) r_pipe[i] <= '0;
      r_adv <= 1'b0;
    end else begin
      r_adv <= pix_en;
      if (pix_en) begin
        r_pipe[0] <= w_in;
        for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign active      = r_pipe[RD_LATENCY-1][0];
  assign hsync       = r_pipe[RD_LATENCY-1][1] ^ SYNC_INV;
  assign vsync       = r_pipe[RD_LATENCY-1][2] ^ SYNC_INV;
  assign frame_start = r_pipe[RD_LATENCY-1][3] & r_adv;
  assign rgb         = active ? fb_data : '0;
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard bench for vga_scanout on a reduced timing set
module tb_vga_scanout;
  localparam int HV = 16, HF = 2, HS = 3, HB = 2;
  localparam int VV = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int SC = 1, COLS = 2, ROWS = 2, LAT = 2;
`ifdef FB_PAGE_EN
  localparam int AW = ROWS + COLS + 1;
`else
  localparam int AW = ROWS + COLS;
`endif

  logic          clk = 1'b0;
  logic          reset_n, pix_en, page_sel;
  logic [AW-1:0] fb_addr;
  logic          fb_rd_en;
  logic [7:0]    fb_data, rgb;
  logic          hsync, vsync, active, frame_start;
  logic [15:0]   hpos, vpos;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1), .SCALE_SHIFT(SC), .FB_COLS_LOG(COLS), .FB_ROWS_LOG(ROWS),
    .PIXEL_W(8), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .page_sel(page_sel),
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_data(fb_data), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .active(active), .frame_start(frame_start),
    .hpos(hpos), .vpos(vpos)
  );

  function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
    return 8'(32'(a) * 37 + 5);
  endfunction

  logic [7:0] m_q [LAT];
  always @(posedge clk) begin
    if (pix_en) begin
      if (fb_rd_en) m_q[0] <= mem_f(fb_addr);
      for (int i = 1; i < LAT; i++) m_q[i] <= m_q[i-1];
    end
  end
  assign fb_data = m_q[LAT-1];

  int total = 0, bad = 0;
  int mh, mv, cyc, fs_last, exp_period, hs_run, exp_hs_w;
  logic [AW-1:0] m_last;
  logic m_page;
  logic [11:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (h=%0d v=%0d)", tag, got, exp, mh, mv);
    end
  endtask

  task automatic reset_model();
    mh = 0; mv = 0; m_last = '0; m_page = 1'b0;
    sb.delete();
    for (int i = 0; i < LAT - 1; i++) sb.push_back(12'b0011_0000_0000);
  endtask

  function automatic logic [AW-1:0] model_addr();
    logic [AW-1:0] a;
    a = AW'(((mv >> SC) % (1 << ROWS)) * (1 << COLS) + ((mh >> SC) % (1 << COLS)));
`ifdef FB_PAGE_EN
    a[AW-1] = m_page;
`endif
    return a;
  endfunction

  task automatic tick(input bit en);
    logic vis, hp, vp;
    logic [AW-1:0] a;
    logic [11:0] e;
    pix_en = en;
    page_sel = 1'($urandom_range(0, 1));
    #1;
    vis = (mh < HV) && (mv < VV);
    a = model_addr();
    if (en) begin
      chk("hpos", 32'(hpos), 32'(mh));
      chk("vpos", 32'(vpos), 32'(mv));
      chk("rd_en", 32'(fb_rd_en), 32'(vis));
      chk("addr", 32'(fb_addr), 32'(vis ? a : m_last));
      hp = (mh >= HV + HF) && (mh < HV + HF + HS);
      vp = (mv >= VV + VF) && (mv < VV + VF + VS);
      e = {(mh == 0 && mv == 0), vis, ~hp, ~vp, vis ? mem_f(a) : 8'h00};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (en) begin
      e = sb.pop_front();
      chk("frame_start", 32'(frame_start), 32'(e[11]));
      chk("active", 32'(active), 32'(e[10]));
      chk("hsync", 32'(hsync), 32'(e[9]));
      chk("vsync", 32'(vsync), 32'(e[8]));
      chk("rgb", 32'(rgb), 32'(e[7:0]));
      if (vis) m_last = a;
      if (mv == VV && mh == 0) m_page = page_sel;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end else begin
      chk("fs_idle", 32'(frame_start), 32'd0);
    end
    if (!hsync) hs_run++;
    else begin
      if (hs_run > 0) chk("hs_width", 32'(hs_run), 32'(exp_hs_w));
      hs_run = 0;
    end
    if (frame_start) begin
      if (fs_last >= 0) chk("frame_period", 32'(cyc - fs_last), 32'(exp_period));
      fs_last = cyc;
    end
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_hpos"}, 32'(hpos), 32'd0);
    chk({tag, "_vpos"}, 32'(vpos), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_rgb"}, 32'(rgb), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_rd_en"}, 32'(fb_rd_en), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; pix_en = 1'b0; page_sel = 1'b0;
    cyc = 0; hs_run = 0; fs_last = -1;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_pins("rst");
    reset_n = 1'b1;

    exp_hs_w = HS; exp_period = HT * VT;
    repeat (2 * HT * VT) tick(1'b1);

    fs_last = -1; exp_hs_w = 4 * HS; exp_period = 4 * HT * VT;
    repeat (HT * VT + 50) begin
      tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    end

    exp_hs_w = HS; fs_last = -1;
    for (int k = 0; k < HT * VT && !(mh == 5 && mv == 3); k++) tick(1'b1);
    chk("pre_reset_pos", 32'(hpos * 256 + vpos), 32'(5 * 256 + 3));
    pix_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_pins("arst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    reset_model();
    hs_run = 0; fs_last = -1; exp_period = HT * VT;
    repeat (HT * VT + 10) tick(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Parametrised VGA timing generator and framebuffer scanout engine; next generation of the fixed 640x400 hard-coded timing logic in the VGA top level. Generates H/V counters, sync pulses and framebuffer read addresses with power-of-two pixel scaling. Compensates the framebuffer read latency so sync, blank and pixel data leave aligned. Sits between the dual-port framebuffer read port and the VGA pins.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
V_VISIBLE, 400, visible lines per frame
V_FRONT, 11, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BACK, 32, vertical back porch
SYNC_ACTIVE_LOW, 1, 1 = sync pins low during pulse
SCALE_SHIFT, 2, each framebuffer pixel is 2^SCALE_SHIFT screen pixels in H and V
FB_COLS_LOG, 8, framebuffer column address bits
FB_ROWS_LOG, 7, framebuffer row address bits
PIXEL_W, 8, pixel width (RGB332 at default)
RD_LATENCY, 1, framebuffer read latency in enabled cycles (1..4)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel-clock enable; all state advances only when high
page_sel  in  1  display page request (used only with FB_PAGE_EN)
fb_addr  out  FB_ROWS_LOG+FB_COLS_LOG (+1 with FB_PAGE_EN)  framebuffer read address
fb_rd_en  out  1  read strobe, high for visible undelayed positions
fb_data  in  PIXEL_W  framebuffer read data, valid RD_LATENCY enabled cycles after fb_addr
rgb  out  PIXEL_W  pixel to DAC, zero when blanked
hsync  out  1  horizontal sync pin
vsync  out  1  vertical sync pin
active  out  1  delayed visible-region flag aligned with rgb
frame_start  out  1  one-clk pulse at first pixel of a frame (aligned output)
hpos  out  16  undelayed horizontal counter
vpos  out  16  undelayed vertical counter

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low (reset_n); no other clock domains.
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (445 at defaults).
- Counters: on clk with pix_en: hpos==H_TOTAL-1 -> hpos=0 and vpos wraps V_TOTAL-1 -> 0 else +1; otherwise hpos+1. pix_en low: everything holds, frame_start forced 0.
- Visible (undelayed): hpos<H_VISIBLE && vpos<V_VISIBLE.
- Sync pulse region: H_VISIBLE+H_FRONT <= hpos < H_VISIBLE+H_FRONT+H_SYNC; same pattern for V. Pin level = pulse XOR SYNC_ACTIVE_LOW... i.e. pin low in pulse when SYNC_ACTIVE_LOW=1, high otherwise.
- fb_addr = {vpos>>SCALE_SHIFT truncated to FB_ROWS_LOG, hpos>>SCALE_SHIFT truncated to FB_COLS_LOG}; registered from counters combinationally (no extra delay). Held at last value when not visible; fb_rd_en=0 there.
- Alignment pipeline: visible, hsync pulse, vsync pulse and frame flag pass through an RD_LATENCY-deep shift register advancing on pix_en. Outputs hsync/vsync/active/frame_start registered from pipeline tail. rgb = fb_data captured when delayed visible, else 0.
- Total latency counters->pins: RD_LATENCY enabled cycles; frame_start asserted on the clk where active first rises at (0,0).
- Reset values: hpos=vpos=0, pipeline cleared, rgb=0, active=0, frame_start=0, fb_rd_en=0, hsync/vsync at inactive level (1 when SYNC_ACTIVE_LOW=1). Reset mid-frame restarts at (0,0) on first pix_en after release.
- Truncation: if visible scaled range exceeds FB dims, address wraps silently (no error).
- Elaboration: RD_LATENCY outside 1..4 or any sync/porch param 0 -> $error.

Optional Feature:
FB_PAGE_EN: adds one MSB to fb_addr selecting display page. page_sel sampled when undelayed vpos==V_VISIBLE and hpos==0 (start of vblank, pix_en high); latched value used for whole next frame, giving tear-free double buffering. Reset value 0. Without macro: page_sel ignored, fb_addr width FB_ROWS_LOG+FB_COLS_LOG.

Test Plan:
- Defaults, pix_en=1, run 2 frames -> hsync low exactly 96 clk per line starting hpos 656; vsync low lines 411-412; frame period 356000 clk.
- fb_data = address low byte model, RD_LATENCY=1 -> rgb at pins equals data of (vpos>>2,hpos>>2) one clk later; rgb=0 at hpos 640..799 and vpos>=400.
- RD_LATENCY=3 -> active, hsync, vsync, rgb all shifted exactly 3 clk vs undelayed counters; frame_start one pulse per frame.
- pix_en toggled 1-of-4 -> counters advance once per 4 clk; sync widths measured 384 clk; frame_start still single-clk.
- reset_n pulsed low at hpos=300,vpos=200 -> outputs immediately reset values asynchronously; restart at (0,0).
- FB_PAGE_EN, toggle page_sel mid-frame -> fb_addr MSB changes only at start of following frame.
